// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//   Programmable clock divider with run / halt / single-step control for the
//   CPU core clock. The divided clock has a period of 2*div_cur sys_clk cycles
//   and a 50% duty cycle. Halting waits for the low phase, so the CPU never
//   sees a shortened high pulse. Single-step produces exactly one full divided
//   period and then halts again. In bypass, while running, clk follows sys_clk.
//
// Ports
//   sys_clk   in   1      system clock, all logic on posedge
//   reset     in   1      asynchronous, active-high reset
//   div_half  in   CNT_W  new half-period in sys_clk cycles (0 is treated as 1)
//   div_load  in   1      pulse: latch div_half into the pending register
//   bypass    in   1      1: clk = sys_clk while running
//   mode      in   2      00 run, 01 halt, 10 step-enable, 11 halt
//   step_req  in   1      pulse: run one divided period while halted (mode 10)
//   clk       out  1      divided / gated CPU clock
//   tick      out  1      high for one sys_clk cycle as clk rises
//   halted    out  1      high while halted
//   div_cur   out  CNT_W  half-period currently in effect
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int               CNT_W       = 26,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(2)
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] div_half,
    input  logic             div_load,
    input  logic             bypass,
    input  logic [1:0]       mode,
    input  logic             step_req,
    output logic             clk,
    output logic             tick,
    output logic             halted,
    output logic [CNT_W-1:0] div_cur
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2,
        S_STEP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;

    logic             wrap;
    logic             rise;
    logic             fall;
    logic             mode_run;
    logic             do_count;
    logic             apply_pend;
    logic             byp_active;

    // End of a half-period: the divided clock toggles on this cycle.
    assign wrap     = (cnt_q == div_cur_q - CNT_W'(1));
    assign rise     = wrap & ~clk_q;
    assign fall     = wrap &  clk_q;
    assign mode_run = (mode == 2'b00);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        div_cur_d  = div_cur_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        do_count   = 1'b0;
        apply_pend = 1'b0;

        case (state_q)
            S_RUN: begin
                if (bypass) begin
                    // Counter idles at 0 while the raw clock is passed through.
                    cnt_d = '0;
                    clk_d = 1'b0;
                    if (!mode_run) begin
                        state_d    = S_HALTED;
                        apply_pend = 1'b1;
                    end
                end else if (!mode_run && !clk_q) begin
                    // Already low: stop right here, no partial high pulse possible.
                    state_d    = S_HALTED;
                    cnt_d      = '0;
                    clk_d      = 1'b0;
                    apply_pend = 1'b1;
                end else begin
                    do_count = 1'b1;
                    if (!mode_run) begin
                        // High phase must finish first; if it ends this very
                        // cycle we can go straight to halted.
                        state_d = fall ? S_HALTED : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                do_count = 1'b1;
                if (mode_run) begin
                    state_d = S_RUN;
                end else if (fall) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (mode_run) begin
                    state_d = S_RUN;
                end else if (mode == 2'b10 && step_req) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                // Runs to completion regardless of mode; falling wrap ends it.
                do_count = 1'b1;
                if (fall) begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        if (do_count) begin
            cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
            clk_d  = wrap ? ~clk_q : clk_q;
            tick_d = rise;
            if (wrap) begin
                apply_pend = 1'b1;
            end
        end

        // Ratio changes only at half-period boundaries or on entering halt.
        if (apply_pend && pend_v_q) begin
            div_cur_d = pend_q;
            pend_v_d  = 1'b0;
        end

        // A load coinciding with an application waits for the next boundary.
        if (div_load) begin
            pend_d   = (div_half == '0) ? CNT_W'(1) : div_half;
            pend_v_d = 1'b1;
        end

        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            halted_q  <= 1'b0;
            div_cur_q <= DIV_DEFAULT;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            halted_q  <= halted_d;
            div_cur_q <= div_cur_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
        end
    end

    // Bypass is the only combinational path to the outputs; not glitch-free,
    // so bypass is expected to change only while halted or in reset.
    assign byp_active = (state_q == S_RUN) && bypass;
    assign clk        = byp_active ? sys_clk : clk_q;
    assign tick       = byp_active | tick_q;
    assign halted     = halted_q;
    assign div_cur    = div_cur_q;

endmodule
